// File: rtl/sync_data_settle_filter.sv
// Settle filter: tracks a candidate word and counts how many consecutive edges
// it has been sampled unchanged; pulses stable_o on the edge it may be offered.
module sync_data_settle_filter #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  settle_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [DATA_WIDTH-1:0] applied_i,
  output logic                  stable_o,
  output logic [DATA_WIDTH-1:0] cand_o
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  live;

  // A revert to the applied value is handled by the FSM; the filter just holds.
  assign live = settle_i && (in_data_i != applied_i);

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      cand_d = in_data_i;
      cnt_d  = '0;
    end else if (live) begin
      if (in_data_i != cand_q) begin
        cand_d = in_data_i;
        cnt_d  = '0;
      end else if (cnt_q != LAST) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stable_o = live && (in_data_i == cand_q) && (cnt_q == LAST);
  assign cand_o   = cand_q;
endmodule

// File: rtl/sync_data_update_ctrl.sv
// Change detector after a multi-bit synchroniser: settles each new word, offers
// it once over valid/ready, and tracks applied value, update count and overrun.
module sync_data_update_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [DATA_WIDTH-1:0]  upd_data,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [DATA_WIDTH-1:0]  applied_data,
  output logic [COUNT_WIDTH-1:0] update_count,
  output logic                   pending,
  output logic                   overrun
);
  typedef enum logic [1:0] {IDLE, SETTLE, OFFER} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  upd_data_q, applied_q, cand;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   upd_valid_q, overrun_q, stable, start;

  assign start = (state_q == IDLE) && (in_data != applied_q);

  sync_data_settle_filter #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_filt (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .settle_i (state_q == SETTLE),
    .in_data_i(in_data),
    .applied_i(applied_q),
    .stable_o (stable),
    .cand_o   (cand)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      upd_data_q  <= '0;
      upd_valid_q <= 1'b0;
      applied_q   <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= SETTLE;
        SETTLE: begin
          if (in_data == applied_q) begin
            state_q <= IDLE;
          end else if (stable) begin
            upd_data_q  <= cand;
            upd_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (in_data != upd_data_q) overrun_q <= 1'b1;
          if (upd_ready) begin
            applied_q   <= upd_data_q;
            count_q     <= count_q + COUNT_WIDTH'(1);
            upd_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign upd_data     = upd_data_q;
  assign upd_valid    = upd_valid_q;
  assign applied_data = applied_q;
  assign update_count = count_q;
  assign overrun      = overrun_q;
  assign pending      = (in_data != applied_q) && !(upd_valid_q && (in_data == upd_data_q));
endmodule

// File: tb/tb_sync_data_update_ctrl.sv
// Directed bench: stimulus queues expected offers (value + cycle of first valid),
// a negedge monitor pops and compares each offer as the DUT raises upd_valid.
module tb_sync_data_update_ctrl;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        upd_ready = 1'b0;
  logic [7:0]  upd_data, applied_data;
  logic        upd_valid, pending, overrun;
  logic [15:0] update_count;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  logic last_v = 1'b0;

  sync_data_update_ctrl #(.DATA_WIDTH(8), .SETTLE_CYCLES(SC), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .upd_data(upd_data), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .applied_data(applied_data), .update_count(update_count),
    .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_offer(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising upd_valid must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && upd_valid && !last_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_offer: got data %0h, expected no offer (cycle %0d)", upd_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("offer_data", 32'(upd_data), 32'(e.d));
        chk("offer_cycle", 32'(cyc), 32'(e.c));
      end
    end
    last_v = upd_valid;
  end

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_valid", 32'(upd_valid), 0);
    chk("rst_upd_data", 32'(upd_data), 0);
    chk("rst_applied", 32'(applied_data), 0);
    chk("rst_count", 32'(update_count), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // zero after reset is never offered
    step(20);
    chk("zero_pending", 32'(pending), 0);
    chk("zero_count", 32'(update_count), 0);

    // plain update with ready tied high
    upd_ready = 1'b1;
    in_data = 8'h5A;
    expect_offer(8'h5A, cyc + 1 + SC);
    step(SC + 3);
    chk("p2_applied", 32'(applied_data), 32'h5A);
    chk("p2_count", 32'(update_count), 1);
    chk("p2_valid_low", 32'(upd_valid), 0);

    // short excursion that reverts: no offer
    in_data = 8'h33;
    step(2);
    in_data = 8'h5A;
    step(10);
    chk("p3_count", 32'(update_count), 1);
    chk("p3_overrun", 32'(overrun), 0);
    chk("p3_pending", 32'(pending), 0);

    // glitch during settling restarts the filter
    in_data = 8'h11;
    step(2);
    in_data = 8'h12;
    expect_offer(8'h12, cyc + 1 + SC);
    step(SC + 4);
    chk("p4_applied", 32'(applied_data), 32'h12);
    chk("p4_count", 32'(update_count), 2);

    // stalled offer with input moving underneath it
    upd_ready = 1'b0;
    in_data = 8'h77;
    expect_offer(8'h77, cyc + 1 + SC);
    step(SC + 2);
    in_data = 8'h78;
    step(10);
    chk("p5_hold_data", 32'(upd_data), 32'h77);
    chk("p5_hold_valid", 32'(upd_valid), 1);
    chk("p5_overrun", 32'(overrun), 1);
    chk("p5_pending", 32'(pending), 1);
    upd_ready = 1'b1;
    expect_offer(8'h78, cyc + 2 + SC);
    step(1);
    chk("p5_applied_77", 32'(applied_data), 32'h77);
    chk("p5_count_3", 32'(update_count), 3);
    step(SC + 3);
    chk("p5_applied_78", 32'(applied_data), 32'h78);
    chk("p5_count_4", 32'(update_count), 4);
    chk("p5_valid_low", 32'(upd_valid), 0);

    // reset in the middle of an offer
    upd_ready = 1'b0;
    in_data = 8'hA5;
    expect_offer(8'hA5, cyc + 1 + SC);
    step(SC + 2);
    chk("p6_pre_valid", 32'(upd_valid), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("p6_valid", 32'(upd_valid), 0);
    chk("p6_upd_data", 32'(upd_data), 0);
    chk("p6_applied", 32'(applied_data), 0);
    chk("p6_count", 32'(update_count), 0);
    chk("p6_overrun", 32'(overrun), 0);
    chk("p6_pending", 32'(pending), 1);
    expect_offer(8'hA5, cyc + 1 + SC);
    upd_ready = 1'b1;
    step(SC + 3);
    chk("p6_reapplied", 32'(applied_data), 32'hA5);
    chk("p6_recount", 32'(update_count), 1);

    step(2);
    chk("offers_outstanding", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
